chip_test_ctrl: RTL

- Front-end controller for the chip-checker test stage. Debounces the operator Start button and issues a one-cycle Run to the chip tester.
- Waits for the tester's Done, samples its RSLT after it settles, and releases the tester with a DISP_RSLT pulse.
- Latches pass/fail to the LEDs and keeps saturating pass/fail tallies.
- Watchdog: a tester that never raises Done is recorded as a failed test with Timeout set.

---
 rtl/chip_test_ctrl_if.sv | 30 +++
 rtl/chip_test_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/chip_test_ctrl_if.sv
// chip_test_ctrl_if: tester handshake and status bundle for the chip test front-end.
// Ports (signals):
//   Start, Done, RSLT             operator button and tester flags into the controller
//   Run, DISP_RSLT                one-cycle launch / release pulses to the tester
//   Busy, Pass_LED, Fail_LED,     controller status
//   Timeout, Pass_Count, Fail_Count
// slave = controller side, master = operator/tester side.
interface chip_test_ctrl_if;
    logic       Start;
    logic       Done;
    logic       RSLT;
    logic       Run;
    logic       DISP_RSLT;
    logic       Busy;
    logic       Pass_LED;
    logic       Fail_LED;
    logic       Timeout;
    logic [7:0] Pass_Count;
    logic [7:0] Fail_Count;

    modport slave (
        input  Start, Done, RSLT,
        output Run, DISP_RSLT, Busy, Pass_LED, Fail_LED, Timeout, Pass_Count, Fail_Count
    );

    modport master (
        output Start, Done, RSLT,
        input  Run, DISP_RSLT, Busy, Pass_LED, Fail_LED, Timeout, Pass_Count, Fail_Count
    );
endinterface

// File: rtl/chip_test_ctrl.sv
// chip_test_ctrl: debounces Start, launches the tester, waits for a settled Done
// (or a watchdog timeout), reports the result and keeps saturating pass/fail tallies.
// Ports:
//   Clk    system clock
//   Reset  synchronous active-high reset
//   bus    chip_test_ctrl_if.slave (Start/Done/RSLT in; Run/DISP_RSLT/status out)
module chip_test_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SETTLE_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic             Clk,
    input  logic             Reset,
    chip_test_ctrl_if.slave  bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_MAX  = ST_W'(SETTLE_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, REPORT} state_t;

    state_t          state, state_nxt;
    logic [1:0]      sync_q;
    logic            deb_level;
    logic [DB_W-1:0] deb_cnt;
    logic            start_evt;
    logic [ST_W-1:0] settle_cnt, settle_nxt;
    logic [WD_W-1:0] wd_cnt, wd_nxt;
    logic            settle_hit, wd_hit;
    logic            result_q, pass_led, fail_led, timeout_q;
    logic [7:0]      pass_cnt, fail_cnt;

    // deb_cnt counts consecutive samples that disagree with the debounced level;
    // the level flips on the last of them, so a rising flip is the start event.
    assign start_evt  = sync_q[1] && !deb_level && deb_cnt == DB_LAST;
    assign settle_nxt = bus.Done ? settle_cnt + 1'b1 : '0;
    assign wd_nxt     = wd_cnt + 1'b1;
    assign settle_hit = settle_nxt == ST_MAX;
    assign wd_hit     = wd_nxt == WD_MAX;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q    <= '0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.Start};
            if (sync_q[1] == deb_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DB_LAST) begin
                deb_level <= sync_q[1];
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = start_evt ? LAUNCH : IDLE;
            LAUNCH:    state_nxt = WAIT_DONE;
            WAIT_DONE: state_nxt = (settle_hit || wd_hit) ? REPORT : WAIT_DONE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            settle_cnt <= '0;
            wd_cnt     <= '0;
            result_q   <= 1'b0;
            pass_led   <= 1'b0;
            fail_led   <= 1'b0;
            timeout_q  <= 1'b0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            settle_cnt <= (state == WAIT_DONE) ? settle_nxt : '0;
            wd_cnt     <= (state == WAIT_DONE) ? wd_nxt : '0;
            if (state == IDLE && start_evt) begin
                pass_led  <= 1'b0;
                fail_led  <= 1'b0;
                timeout_q <= 1'b0;
            end
            // A settled Done in the same cycle as the watchdog wins.
            if (state == WAIT_DONE) begin
                if (settle_hit) begin
                    result_q <= bus.RSLT;
                end else if (wd_hit) begin
                    result_q  <= 1'b0;
                    timeout_q <= 1'b1;
                end
            end
            if (state == REPORT) begin
                pass_led <= result_q;
                fail_led <= !result_q;
                if (result_q && pass_cnt != 8'hFF)  pass_cnt <= pass_cnt + 1'b1;
                if (!result_q && fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 1'b1;
            end
        end
    end

    assign bus.Run        = state == LAUNCH;
    assign bus.DISP_RSLT  = state == REPORT;
    assign bus.Busy       = state != IDLE;
    assign bus.Pass_LED   = pass_led;
    assign bus.Fail_LED   = fail_led;
    assign bus.Timeout    = timeout_q;
    assign bus.Pass_Count = pass_cnt;
    assign bus.Fail_Count = fail_cnt;
endmodule
